split_arbiter: RTL

Packet-granular round-robin arbiter that shares one width-splitting bridge input between `NUM_REQ` upstream producers. Each requester presents wide beats with a valid/ready/last handshake. The arbiter grants one requester at a time and holds the grant until that requester's `last` beat has been accepted. Granted beats pass through a single registered output stage that drives the bridge's `vld_i/din/last_i/rdy_o` port, and the stage tags each beat with its source index.

---
 rtl/split_arbiter_if.sv | 32 +++
 rtl/split_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/split_arbiter_if.sv
// Requester-side and bridge-side handshake bundle for split_arbiter.
// slave: the arbiter's view; master: the environment driving requesters and the bridge.
interface split_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DIN_W   = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
);
  // Upstream requesters
  logic [NUM_REQ-1:0]                          req_vld_i;
  logic [NUM_REQ-1:0][DIN_W-1:0][DATA_W-1:0]   req_din_i;
  logic [NUM_REQ-1:0]                          req_last_i;
  logic [NUM_REQ-1:0]                          req_rdy_o;
  // Downstream bridge
  logic                                        vld_o;
  logic [DIN_W-1:0][DATA_W-1:0]                dout;
  logic                                        last_o;
  logic [SRC_W-1:0]                            src_o;
  logic                                        rdy_i;
  // Status
  logic                                        busy_o;

  modport slave (
    input  req_vld_i, req_din_i, req_last_i, rdy_i,
    output req_rdy_o, vld_o, dout, last_o, src_o, busy_o
  );

  modport master (
    output req_vld_i, req_din_i, req_last_i, rdy_i,
    input  req_rdy_o, vld_o, dout, last_o, src_o, busy_o
  );
endinterface

// File: rtl/split_arbiter.sv
// Packet-granular round-robin arbiter feeding a single registered output stage.
// A grant is locked from the first non-last beat until the last beat is accepted.
module split_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DIN_W   = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input logic           clk,
  input logic           rst,
  split_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                       state_q;
  logic [SRC_W-1:0]             ptr_q;
  logic [SRC_W-1:0]             grant_q;

  logic                         out_vld_q;
  logic [DIN_W-1:0][DATA_W-1:0] out_data_q;
  logic                         out_last_q;
  logic [SRC_W-1:0]             out_src_q;

  logic                         rr_found;
  logic [SRC_W-1:0]             rr_idx;
  logic [SRC_W:0]               cand;
  logic [SRC_W-1:0]             sel;
  logic [SRC_W-1:0]             sel_next;
  logic                         sel_vld;
  logic                         can_take;
  logic                         accept;

  // Round-robin search: first valid requester starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      if (!rr_found && bus.req_vld_i[cand[SRC_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // Selection, per-requester ready and acceptance; ready is suppressed while in reset.
  always_comb begin
    can_take = (!out_vld_q || bus.rdy_i) && !rst;
    if (state_q == StLocked) begin
      sel     = grant_q;
      sel_vld = 1'b1;
    end else begin
      sel     = rr_idx;
      sel_vld = rr_found;
    end
    bus.req_rdy_o = '0;
    if (sel_vld && can_take) begin
      bus.req_rdy_o[sel] = 1'b1;
    end
    accept   = sel_vld && can_take && bus.req_vld_i[sel];
    sel_next = (sel == SRC_W'(NUM_REQ - 1)) ? '0 : sel + SRC_W'(1);
  end

  // Grant FSM, round-robin pointer and the one-entry output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_q    <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q  <= '0;
    end else begin
      if (accept) begin
        out_vld_q  <= 1'b1;
        out_data_q <= bus.req_din_i[sel];
        out_last_q <= bus.req_last_i[sel];
        out_src_q  <= sel;
        if (bus.req_last_i[sel]) begin
          state_q <= StIdle;
          ptr_q   <= sel_next;
        end else begin
          state_q <= StLocked;
          grant_q <= sel;
        end
      end else if (bus.rdy_i) begin
        // Beat consumed by the bridge; payload fields keep their last values.
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.vld_o  = out_vld_q;
  assign bus.dout   = out_data_q;
  assign bus.last_o = out_last_q;
  assign bus.src_o  = out_src_q;
  assign bus.busy_o = (state_q == StLocked);

endmodule
